// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the RV32I integer ALU slice: the alu_op encoding,
//   the RV32I major opcodes and funct7 values the decoder recognises, the
//   payload record carried from decode to the issue buffer, and a reference
//   ALU evaluation function used by the execution stage.
package alu_pkg;

  // ALU operation encoding seen on the alu_op port
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // RV32I major opcodes handled by this block
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 values: base encoding and the alternate (SUB/SRA) encoding
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One decoded operation as held in the issue buffer
  typedef struct packed {
    alu_op_e     alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;
  } alu_pay_t;

  // Result of one ALU operation; shifts use only the low five bits of b
  function automatic logic [31:0] alu_exec(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_SLL:   r = a << b[4:0];
      ALU_SLT:   r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  r = {31'b0, a < b};
      ALU_XOR:   r = a ^ b;
      ALU_SRL:   r = a >> b[4:0];
      ALU_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:    r = a | b;
      ALU_AND:   r = a & b;
      ALU_PASSB: r = b;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode
//   Purely combinational RV32I decoder for the integer ALU subset
//   (OP, OP-IMM, LUI, AUIPC). Anything else, or a bad funct7 field, is
//   reported as illegal with a zeroed operation and no write-back.
// Ports
//   instr      in   32  instruction word
//   pc         in   32  instruction address (AUIPC operand)
//   rs1_data   in   32  register read of instr[19:15]
//   rs2_data   in   32  register read of instr[24:20]
//   alu_op     out   4  ALU operation (alu_op_e encoding)
//   operand_a  out  32  ALU operand A
//   operand_b  out  32  ALU operand B
//   rd_addr    out   5  destination register
//   rd_we      out   1  write-back enable
//   illegal    out   1  unsupported encoding
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [3:0]  alu_op,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  alu_op_e     op;
  logic [31:0] a;
  logic [31:0] b;
  logic        bad;

  // Operation selection. Each major opcode picks its operands, then funct3
  // picks the operation; funct7 only matters for the shift and ADD/SUB
  // forms. An illegal result overrides everything with zeros at the end so
  // nothing downstream can act on a half-decoded instruction.
  always_comb begin
    op  = ALU_ADD;
    a   = '0;
    b   = '0;
    bad = 1'b0;
    case (opcode)
      OPC_OP: begin
        a = rs1_data;
        b = rs2_data;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          op = ALU_SRA;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        a = rs1_data;
        b = imm_i;
        case (funct3)
          3'b000: op = ALU_ADD;
          3'b010: op = ALU_SLT;
          3'b011: op = ALU_SLTU;
          3'b100: op = ALU_XOR;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          3'b001: begin
            b = shamt;
            if (funct7 == F7_BASE) op = ALU_SLL;
            else bad = 1'b1;
          end
          default: begin
            b = shamt;
            if (funct7 == F7_BASE) op = ALU_SRL;
            else if (funct7 == F7_ALT) op = ALU_SRA;
            else bad = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        op = ALU_PASSB;
        a  = '0;
        b  = imm_u;
      end
      OPC_AUIPC: begin
        op = ALU_ADD;
        a  = pc;
        b  = imm_u;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      op = ALU_ADD;
      a  = '0;
      b  = '0;
    end
  end

  assign alu_op    = op;
  assign operand_a = a;
  assign operand_b = b;
  assign rd_addr   = instr[11:7];
  assign illegal   = bad;
  // x0 is hard-wired to zero, so writes to it are suppressed here
  assign rd_we     = !bad && (instr[11:7] != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// alu_issue
//   Decodes an RV32I ALU instruction and issues it one cycle later through a
//   valid/ready output. With USE_SKID=1 a main register plus a skid register
//   give full throughput while in_ready stays a flop output; with USE_SKID=0
//   a single register is used and in_ready is combinational.
// Ports
//   clk        in    1  rising-edge clock
//   rst        in    1  synchronous active-high reset
//   flush      in    1  discard all buffered entries
//   in_valid   in    1  upstream instruction valid
//   in_ready   out   1  block can accept an instruction
//   instr      in   32  instruction word
//   pc         in   32  instruction address
//   rs1_data   in   32  register read of instr[19:15]
//   rs2_data   in   32  register read of instr[24:20]
//   out_valid  out   1  issued operation valid
//   out_ready  in    1  downstream accepts
//   alu_op     out   4  ALU operation
//   operand_a  out  32  ALU operand A
//   operand_b  out  32  ALU operand B
//   rd_addr    out   5  destination register
//   rd_we      out   1  write-back enable
//   illegal    out   1  unsupported encoding
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned USE_SKID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic        illegal
);

  logic [3:0]  dec_alu_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_rd_addr;
  logic        dec_rd_we;
  logic        dec_illegal;

  alu_decode u_decode (
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .alu_op    (dec_alu_op),
    .operand_a (dec_a),
    .operand_b (dec_b),
    .rd_addr   (dec_rd_addr),
    .rd_we     (dec_rd_we),
    .illegal   (dec_illegal)
  );

  alu_pay_t dec_pay;

  always_comb begin
    dec_pay.alu_op    = alu_op_e'(dec_alu_op);
    dec_pay.operand_a = dec_a;
    dec_pay.operand_b = dec_b;
    dec_pay.rd_addr   = dec_rd_addr;
    dec_pay.rd_we     = dec_rd_we;
    dec_pay.illegal   = dec_illegal;
  end

  alu_pay_t main_pay_q, main_pay_d;
  alu_pay_t skid_pay_q, skid_pay_d;
  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     in_ready_q, in_ready_d;
  logic     in_fire;
  logic     out_fire;

  // The skid variant exposes a registered ready; the single-register
  // variant must look at out_ready directly to keep accepting while draining.
  assign in_ready = (USE_SKID != 0) ? in_ready_q : (!main_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid_q && out_ready;

  // Buffer update. The main register refills whenever it is empty or being
  // drained, preferring the older skid entry over the new input so order is
  // kept. A new input that arrives while main is stalled parks in skid;
  // in_ready only admits it when skid is empty, so skid never overflows.
  always_comb begin
    main_pay_d   = main_pay_q;
    skid_pay_d   = skid_pay_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_pay_d   = skid_pay_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_pay_d   = dec_pay;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire && USE_SKID != 0) begin
      skid_valid_d = 1'b1;
      skid_pay_d   = dec_pay;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_pay_q   <= '0;
      skid_pay_q   <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_pay_q   <= main_pay_d;
      skid_pay_q   <= skid_pay_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid = main_valid_q;
  assign alu_op    = main_pay_q.alu_op;
  assign operand_a = main_pay_q.operand_a;
  assign operand_b = main_pay_q.operand_b;
  assign rd_addr   = main_pay_q.rd_addr;
  assign rd_we     = main_pay_q.rd_we;
  assign illegal   = main_pay_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
//   Bench for alu_issue (USE_SKID=1). A queue holds the operations the
//   block should currently be buffering, oldest first; each cycle the head
//   of the queue must appear on the outputs and the queue depth decides
//   out_valid and in_ready. Expected payloads come from a table-driven
//   RV32I decode written from the instruction set rules.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;

  alu_issue #(.USE_SKID(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t model_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic last_in_fire;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference decode: funct3 indexes the operation table; funct7 legality
  // is applied as the instruction set defines it.
  function automatic exp_t refDecode(logic [31:0] w, logic [31:0] ipc, logic [31:0] r1, logic [31:0] r2);
    exp_t e;
    int   f3_op [8];
    int   f3;
    int   f7;
    int   opc;
    f3_op = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    opc = int'(w[6:0]);
    e.ill = 1'b1;
    e.op  = 4'd0;
    e.a   = 32'd0;
    e.b   = 32'd0;
    if (opc == 'h33) begin
      e.a = r1;
      e.b = r2;
      if (f7 == 0) begin
        e.ill = 1'b0;
        e.op  = 4'(f3_op[f3]);
      end else if (f7 == 'h20 && f3 == 0) begin
        e.ill = 1'b0;
        e.op  = 4'd1;
      end else if (f7 == 'h20 && f3 == 5) begin
        e.ill = 1'b0;
        e.op  = 4'd7;
      end
    end else if (opc == 'h13) begin
      e.a = r1;
      if (f3 == 1 || f3 == 5) begin
        e.b = 32'(w[24:20]);
        if (f7 == 0) begin
          e.ill = 1'b0;
          e.op  = 4'(f3_op[f3]);
        end else if (f3 == 5 && f7 == 'h20) begin
          e.ill = 1'b0;
          e.op  = 4'd7;
        end
      end else begin
        e.b   = 32'($signed(w[31:20]));
        e.ill = 1'b0;
        e.op  = 4'(f3_op[f3]);
      end
    end else if (opc == 'h37) begin
      e.ill = 1'b0;
      e.op  = 4'd10;
      e.b   = w & 32'hFFFF_F000;
    end else if (opc == 'h17) begin
      e.ill = 1'b0;
      e.a   = ipc;
      e.b   = w & 32'hFFFF_F000;
    end
    if (e.ill) begin
      e.op = 4'd0;
      e.a  = 32'd0;
      e.b  = 32'd0;
    end
    e.rd = w[11:7];
    e.we = !e.ill && (w[11:7] != 5'd0);
    return e;
  endfunction

  // One cycle: drive inputs, compare outputs against the queue head,
  // step across the clock edge and update the queue.
  task automatic applyStimulus(input logic iv, input logic [31:0] ins, input logic [31:0] ipc,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic ordy, input logic fl);
    exp_t e;
    logic mdl_in_ready;
    logic in_fire;
    logic out_fire;
    in_valid  = iv;
    instr     = ins;
    pc        = ipc;
    rs1_data  = r1;
    rs2_data  = r2;
    out_ready = ordy;
    flush     = fl;
    mdl_in_ready = (model_q.size() < 2);
    checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
    checkOutput("in_ready", 32'(in_ready), 32'(mdl_in_ready));
    if (model_q.size() > 0) begin
      e = model_q[0];
      checkOutput("alu_op", 32'(alu_op), 32'(e.op));
      checkOutput("operand_a", operand_a, e.a);
      checkOutput("operand_b", operand_b, e.b);
      checkOutput("rd_addr", 32'(rd_addr), 32'(e.rd));
      checkOutput("rd_we", 32'(rd_we), 32'(e.we));
      checkOutput("illegal", 32'(illegal), 32'(e.ill));
    end
    in_fire  = iv && mdl_in_ready;
    out_fire = (model_q.size() > 0) && ordy;
    e = refDecode(ins, ipc, r1, r2);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (out_fire) void'(model_q.pop_front());
      if (in_fire) model_q.push_back(e);
    end
    last_in_fire = in_fire && !fl;
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    checkOutput({tag, "_operand_a"}, operand_a, 32'd0);
    checkOutput({tag, "_operand_b"}, operand_b, 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    checkOutput({tag, "_rd_we"}, 32'(rd_we), 32'd0);
    checkOutput({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    model_q.delete();
    @(negedge clk);
    checkAllZero(tag);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    int sel;
    w = $urandom();
    sel = $urandom_range(0, 9);
    if (sel <= 3) w[6:0] = 7'h33;
    else if (sel <= 6) w[6:0] = 7'h13;
    else if (sel == 7) w[6:0] = 7'h37;
    else if (sel == 8) w[6:0] = 7'h17;
    sel = $urandom_range(0, 3);
    if (sel == 0) w[31:25] = 7'h00;
    else if (sel == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  logic [31:0] ops [4];
  int          k;
  int          cyc;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    instr = '0;
    pc = '0;
    rs1_data = '0;
    rs2_data = '0;
    out_ready = 1'b0;
    last_in_fire = 1'b0;
    @(posedge clk);
    doReset("reset");

    // sub x2,x1,x2 with rs1=5, rs2=7
    applyStimulus(1'b1, 32'h4020_8133, 32'h100, 32'd5, 32'd7, 1'b0, 1'b0);
    checkOutput("sub_valid", 32'(out_valid), 32'd1);
    checkOutput("sub_op", 32'(alu_op), 32'd1);
    checkOutput("sub_a", operand_a, 32'd5);
    checkOutput("sub_b", operand_b, 32'd7);
    checkOutput("sub_rd", 32'(rd_addr), 32'd2);
    checkOutput("sub_we", 32'(rd_we), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // slti x1,x1,-1
    applyStimulus(1'b1, 32'hFFF0_A093, 32'h104, 32'h1234, 32'h0, 1'b1, 1'b0);
    checkOutput("slti_op", 32'(alu_op), 32'd3);
    checkOutput("slti_b", operand_b, 32'hFFFF_FFFF);
    // lui x5,0x12345
    applyStimulus(1'b1, 32'h1234_52B7, 32'h108, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
    checkOutput("lui_op", 32'(alu_op), 32'd10);
    checkOutput("lui_a", operand_a, 32'd0);
    checkOutput("lui_b", operand_b, 32'h1234_5000);
    // jal: unsupported opcode
    applyStimulus(1'b1, 32'h0000_006F, 32'h10C, 32'h11, 32'h22, 1'b1, 1'b0);
    checkOutput("jal_ill", 32'(illegal), 32'd1);
    checkOutput("jal_we", 32'(rd_we), 32'd0);
    checkOutput("jal_op", 32'(alu_op), 32'd0);
    // srli with funct7=0000001
    applyStimulus(1'b1, 32'h0220_D093, 32'h110, 32'h33, 32'h44, 1'b1, 1'b0);
    checkOutput("srli_ill", 32'(illegal), 32'd1);
    checkOutput("srli_we", 32'(rd_we), 32'd0);
    checkOutput("srli_op", 32'(alu_op), 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Four back-to-back ops, downstream stalled for three cycles
    ops[0] = 32'h0020_81B3;
    ops[1] = 32'h4030_5233;
    ops[2] = 32'h0051_0293;
    ops[3] = 32'h0000_1317;
    k = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) checkOutput("skid_in_ready_low", 32'(in_ready), 32'd0);
      if (c >= 3 && c <= 6) checkOutput("skid_throughput", 32'(out_valid), 32'd1);
      applyStimulus(k < 4, ops[k % 4], 32'h200 + 32'(k * 4), 32'(k + 1), 32'(k + 10), c >= 3, 1'b0);
      if (last_in_fire) k++;
    end
    checkOutput("skid_all_accepted", 32'(k), 32'd4);
    checkOutput("skid_drained", 32'(out_valid), 32'd0);

    // Flush with both entries full and a new instruction offered
    applyStimulus(1'b1, 32'h0010_0093, 32'h300, 32'd1, 32'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0020_0113, 32'h304, 32'd3, 32'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0030_0193, 32'h308, 32'd5, 32'd6, 1'b0, 1'b1);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    // Flush against an accepted input: the input must also be dropped
    applyStimulus(1'b1, 32'h0040_0213, 32'h30C, 32'd7, 32'd8, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0050_0293, 32'h310, 32'd9, 32'd9, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++)
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset pulsed while stalled with both entries full
    applyStimulus(1'b1, 32'h0060_0313, 32'h400, 32'd1, 32'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0070_0393, 32'h404, 32'd2, 32'd2, 1'b0, 1'b0);
    in_valid = 1'b1;
    doReset("midstall_reset");
    for (int c = 0; c < 3; c++)
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic
    for (cyc = 0; cyc < 600; cyc++) begin
      applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom(), $urandom(), $urandom(),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end
    for (int c = 0; c < 4; c++)
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter USE_SKID, default 1: 1 = two-entry (main + skid) buffer with full throughput; 0 = single output register.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port flush  input  1  discards all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an instruction.
REQ-008 SHALL have port instr  input  32  RV32I instruction word.
REQ-009 SHALL have port pc  input  32  instruction address.
REQ-010 SHALL have port rs1_data  input  32  register-file read of instr[19:15].
REQ-011 SHALL have port rs2_data  input  32  register-file read of instr[24:20].
REQ-012 SHALL have port out_valid  output  1  issued operation valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port alu_op  output  4  ALU opcode (0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 B-passthrough).
REQ-015 SHALL have port operand_a  output  32  ALU operand A.
REQ-016 SHALL have port operand_b  output  32  ALU operand B.
REQ-017 SHALL have port rd_addr  output  5  destination register (instr[11:7]).
REQ-018 SHALL have port rd_we  output  1  write-back enable.
REQ-019 SHALL have port illegal  output  1  unsupported encoding.

Function
REQ-020 SHALL decode combinationally on input, register on a transfer (in_valid && in_ready); latency exactly 1 cycle from input transfer to out_valid.
REQ-021 SHALL, opcode 0110011 (OP): a=rs1_data, b=rs2_data; funct3 000/001/010/011/100/101/110/111 -> ADD|SUB, SLL, SLT, SLTU, XOR, SRL|SRA, OR, AND; funct7 0100000 selects SUB/SRA and is illegal elsewhere; any funct7 other than 0000000/0100000 illegal.
REQ-022 SHALL, opcode 0010011 (OP-IMM): a=rs1_data, b=sign-extended instr[31:20]; funct3 000 always ADD; SLLI requires instr[31:25]=0000000; SRLI/SRAI require 0000000/0100000; shifts b={27'b0,instr[24:20]}.
REQ-023 SHALL, opcode 0110111 (LUI): alu_op=10, a=0, b={instr[31:12],12'b0}.
REQ-024 SHALL, opcode 0010111 (AUIPC): alu_op=0, a=pc, b={instr[31:12],12'b0}.
REQ-025 SHALL, any other opcode or bad funct field: illegal=1, alu_op=0, a=b=0, rd_we=0.
REQ-026 SHALL drive rd_we=1 only for legal instructions with rd_addr!=0.
REQ-027 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-028 SHALL, USE_SKID=0: in_ready = !out_valid || out_ready.
REQ-029 SHALL, USE_SKID=1: in_ready registered = !skid_valid; input accepted while main stalled goes to skid; skid moves to main on next downstream transfer; sustained 1 op/cycle when out_ready=1.
REQ-030 SHALL order outputs strictly in input order; no drop, no duplicate.
REQ-031 SHALL, flush: clear main and skid valid at next edge; flush wins over a simultaneous input transfer (instruction discarded); in_ready=1 the cycle after.
REQ-032 SHALL allow simultaneous input and output transfers on one edge with no bubble.

Reset
REQ-033 SHALL, on rst: out_valid=0, skid empty, in_ready=1 the following cycle, alu_op=0, operand_a=0, operand_b=0, rd_addr=0, rd_we=0, illegal=0.
REQ-034 SHALL, reset mid-stall: discard buffered entries; rst has priority over flush and transfers.

Structure
REQ-035 SHALL place alu_op encoding enum, RV32I opcode constants and funct7 constants in shared package alu_pkg, also used by the ALU.
REQ-036 SHALL implement decode as combinational sub-module alu_decode (instr, pc, rs1_data, rs2_data -> payload); alu_issue holds buffering/handshake only.

Verification
REQ-037 SHALL check: instr 0x40208133 (sub x2,x1,x2), rs1=5, rs2=7 -> next cycle out_valid=1, alu_op=1, a=5, b=7, rd_addr=2, rd_we=1.
REQ-038 SHALL check: instr 0xFFF0A093 (slti x1,x1,-1) -> alu_op=3, b=0xFFFFFFFF; instr 0x123452B7 (lui x5) -> alu_op=10, a=0, b=0x12345000.
REQ-039 SHALL check: instr 0x0000006F (JAL) and 0x0220D093 (srli bad funct7) -> illegal=1, rd_we=0, alu_op=0.
REQ-040 SHALL check: USE_SKID=1, 4 back-to-back ops, out_ready=0 for 3 cycles -> in_ready falls after 2 accepted, all 4 emerge in order, then 1/cycle.
REQ-041 SHALL check: flush asserted with in_valid=1 and both entries full -> next cycle out_valid=0, in_ready=1, flushed instruction never emitted.
REQ-042 SHALL check: rst pulsed during stall -> all outputs zero next cycle, no stale output after release.
